// File: rtl/span_pkg.sv
// Shared types and defaults for the SPAN margin sequencer slice.
package span_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  // Sequencer states: one GO/WAIT pair per engine, then SUM and a terminal DONE/ERROR.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SCAN_GO,
    ST_SCAN_WAIT,
    ST_SPR_GO,
    ST_SPR_WAIT,
    ST_CRS_GO,
    ST_CRS_WAIT,
    ST_SUM,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  // Stage codes reported on err_stage.
  typedef enum logic [1:0] {
    STG_NONE   = 2'd0,
    STG_SCAN   = 2'd1,
    STG_SPREAD = 2'd2,
    STG_CROSS  = 2'd3
  } stage_t;

endpackage

// File: rtl/span_stage_timer.sv
// Per-stage wait timer: cleared on each engine start, counts wait cycles,
// flags expire when the count reaches TIMEOUT_CYC-1.
module span_stage_timer #(
  parameter int unsigned TIMEOUT_CYC = 1023,
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // Counter: clear wins over enable; holds once at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

  // Expiry decode.
  always_comb begin
    expire = (count == LIMIT);
  end

endmodule

// File: rtl/span_margin_sequencer.sv
// Sequences scanning-risk, intermonth-spread and cross-commodity engines,
// then forms the saturated initial margin.
module span_margin_sequencer
  import span_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  output logic              scan_start,
  input  logic              scan_done,
  input  logic [DATA_W-1:0] scan_risk,
  output logic              spread_start,
  input  logic              spread_done,
  input  logic [DATA_W-1:0] tsc,
  output logic              cross_start,
  input  logic              cross_done,
  input  logic [DATA_W-1:0] cross_charge,
  output logic              busy,
  output logic [DATA_W-1:0] margin,
  output logic              margin_valid,
  output logic              err,
  output logic [1:0]        err_stage
);

  seq_state_t        state, state_nx;
  stage_t            err_stage_r;
  logic [DATA_W-1:0] scan_r, tsc_r, cross_r;
  logic [DATA_W+1:0] sum_full;
  logic [DATA_W-1:0] sum_sat;
  logic              in_go, in_wait, cur_done, tmr_expire;
  logic              abort_hit, accept;
  stage_t            cur_stage;

  span_stage_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (in_go),
    .enable (in_wait && !cur_done),
    .expire (tmr_expire)
  );

  // Decode the engine currently being waited on.
  always_comb begin
    in_go     = 1'b0;
    in_wait   = 1'b0;
    cur_done  = 1'b0;
    cur_stage = STG_NONE;
    case (state)
      ST_SCAN_GO, ST_SPR_GO, ST_CRS_GO: in_go = 1'b1;
      ST_SCAN_WAIT: begin
        in_wait   = 1'b1;
        cur_done  = scan_done;
        cur_stage = STG_SCAN;
      end
      ST_SPR_WAIT: begin
        in_wait   = 1'b1;
        cur_done  = spread_done;
        cur_stage = STG_SPREAD;
      end
      ST_CRS_WAIT: begin
        in_wait   = 1'b1;
        cur_done  = cross_done;
        cur_stage = STG_CROSS;
      end
      default: ;
    endcase
    abort_hit = cmd_abort && (state != ST_IDLE);
    accept    = !abort_hit && cmd_start &&
                (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; abort overrides both start and done.
  always_comb begin
    state_nx = state;
    if (abort_hit) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: if (cmd_start) state_nx = ST_SCAN_GO;
        ST_SCAN_GO:   state_nx = ST_SCAN_WAIT;
        ST_SCAN_WAIT: if (scan_done)   state_nx = ST_SPR_GO;
                      else if (tmr_expire) state_nx = ST_ERROR;
        ST_SPR_GO:    state_nx = ST_SPR_WAIT;
        ST_SPR_WAIT:  if (spread_done) state_nx = ST_CRS_GO;
                      else if (tmr_expire) state_nx = ST_ERROR;
        ST_CRS_GO:    state_nx = ST_CRS_WAIT;
        ST_CRS_WAIT:  if (cross_done)  state_nx = ST_SUM;
                      else if (tmr_expire) state_nx = ST_ERROR;
        ST_SUM:       state_nx = ST_DONE;
        default:      state_nx = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs; starts are one cycle wide because each GO lasts one cycle.
  always_comb begin
    scan_start   = (state == ST_SCAN_GO);
    spread_start = (state == ST_SPR_GO);
    cross_start  = (state == ST_CRS_GO);
    busy         = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERROR);
    margin_valid = (state == ST_DONE);
    err          = (state == ST_ERROR);
    err_stage    = err_stage_r;
  end

  // Saturating three-way sum with two guard bits.
  always_comb begin
    sum_full = {2'b00, scan_r} + {2'b00, tsc_r} + {2'b00, cross_r};
    sum_sat  = (|sum_full[DATA_W+1:DATA_W]) ? '1 : sum_full[DATA_W-1:0];
  end

  // Operand latches, error stage and margin result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_r      <= '0;
      tsc_r       <= '0;
      cross_r     <= '0;
      margin      <= '0;
      err_stage_r <= STG_NONE;
    end else if (abort_hit) begin
      err_stage_r <= STG_NONE;
    end else if (accept) begin
      scan_r      <= '0;
      tsc_r       <= '0;
      cross_r     <= '0;
      err_stage_r <= STG_NONE;
    end else if (in_wait && cur_done) begin
      case (state)
        ST_SCAN_WAIT: scan_r  <= scan_risk;
        ST_SPR_WAIT:  tsc_r   <= tsc;
        ST_CRS_WAIT:  cross_r <= cross_charge;
        default: ;
      endcase
    end else if (in_wait && tmr_expire) begin
      err_stage_r <= cur_stage;
    end else if (state == ST_SUM) begin
      margin <= sum_sat;
    end
  end

endmodule

// File: doc/span_margin_sequencer.md
Name: span_margin_sequencer

Overview:
- Controller that sequences the three SPAN margin engines (scanning risk, intermonth spread, cross-commodity) for one portfolio.
- Issues one-cycle start pulses, waits on each engine's done, latches its result, then forms initial margin = scanning risk + TSC + cross-commodity charge, saturated.
- Sits between the Avalon register front-end, which raises cmd_start after the last operand write, and the engine instances.
- Guarantees each engine sees a clean start only after operands are stable. Gives the bus a stable result with a valid/error status.

Parameters:
- DATA_W, 16, width of engine results and margin.
- TIMEOUT_CYC, 1023, max cycles to wait for any single engine done before flagging error; must be >= 1.
- CNT_W, $clog2(TIMEOUT_CYC+1), timeout counter width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_start  in  1  request a margin run; sampled only in IDLE/DONE/ERROR.
- cmd_abort  in  1  cancel the run in progress; return to IDLE.
- scan_start  out  1  one-cycle start pulse to the scanning-risk engine.
- scan_done  in  1  scanning-risk engine done (level or pulse).
- scan_risk  in  DATA_W  scanning-risk result, valid while scan_done=1.
- spread_start  out  1  one-cycle start pulse to the intermonth engine.
- spread_done  in  1  intermonth engine done.
- tsc  in  DATA_W  total spread charge, valid while spread_done=1.
- cross_start  out  1  one-cycle start pulse to the cross-commodity engine.
- cross_done  in  1  cross-commodity engine done.
- cross_charge  in  DATA_W  cross-commodity credit/charge, valid while cross_done=1.
- busy  out  1  high from the cycle after an accepted cmd_start until DONE/ERROR/IDLE.
- margin  out  DATA_W  initial margin result; holds the last value until the next accepted start.
- margin_valid  out  1  high in DONE.
- err  out  1  high in ERROR (timeout).
- err_stage  out  2  stage that timed out: 1=scan, 2=spread, 3=cross, 0=none.

Behaviour:
- Reset (async assert, sync-released use): state=IDLE; all start pulses 0, busy 0, margin 0, margin_valid 0, err 0, err_stage 0, timeout counter 0, latched operands 0.
- States: IDLE, SCAN_GO, SCAN_WAIT, SPR_GO, SPR_WAIT, CRS_GO, CRS_WAIT, SUM, DONE, ERROR.
- IDLE/DONE/ERROR + cmd_start=1 -> SCAN_GO.
  - Clears margin_valid, err, err_stage and the latched operands.
  - margin holds its old value until SUM.
- *_GO: assert the matching *_start for exactly this one cycle; clear the timeout counter; next state is the matching *_WAIT.
  - The engine's done is ignored in *_GO, so a stale done from a prior run is not taken.
- *_WAIT with done=1: latch the result and go to the next *_GO. Order is scan -> spread -> cross -> SUM.
- *_WAIT with done=0: increment the counter. When the counter reaches TIMEOUT_CYC-1 and done is still 0, go to ERROR with err_stage = stage code.
  - A done arriving in the same cycle as the limit wins: latch and proceed.
- SUM (one cycle): margin <= scan_r + tsc_r + cross_r.
  - Computed at DATA_W+2 bits, unsigned.
  - Saturates to all-ones if the result exceeds 2^DATA_W-1.
  - Next state DONE.
- Latency with zero-wait engines (done=1 on the first WAIT cycle): cmd_start accepted at cycle 0 -> margin_valid=1 at cycle 8. Each extra wait cycle per engine adds 1.
- DONE/ERROR: outputs hold until the next cmd_start or cmd_abort.
- cmd_abort (any non-IDLE state):
  - Next state IDLE; busy 0; margin_valid 0; err 0; no start pulse that cycle.
  - Abort has priority over cmd_start and over done.
- cmd_start while busy: ignored; no restart.
- busy = 1 in all *_GO, *_WAIT and SUM states.
- At most one *_start is high in any cycle.

Decomposition:
- Shared package span_pkg:
  - state enum seq_state_t;
  - stage codes STG_NONE/STG_SCAN/STG_SPREAD/STG_CROSS;
  - localparam default DATA_W.
- Sub-module span_stage_timer: counter with clear/enable/expire and TIMEOUT_CYC parameter. It is reused once here and is the natural split.
- The saturating adder stays inline.

Test Plan:
- Nominal, zero-wait engines: cmd_start, then scan_risk=1000, tsc=200, cross_charge=50, each done on the first WAIT cycle -> starts pulse in order, one cycle each; margin_valid at cycle 8; margin=1250.
- Delayed dones: scan done after 5 cycles, spread after 3, cross after 0 -> margin_valid at cycle 16; busy high cycles 1-15; values latched correctly when inputs change after done.
- Saturation: scan=0xF000, tsc=0x0F00, cross=0x0200 -> margin=0xFFFF, margin_valid=1, err=0.
- Timeout: TIMEOUT_CYC=8, spread_done never asserted -> ERROR after 8 SPR_WAIT cycles; err=1, err_stage=2, cross_start never pulsed. A later cmd_start clears err and reruns.
- Abort and reset mid-run: cmd_abort during SCAN_WAIT together with scan_done=1 -> IDLE, no spread_start, margin unchanged. Async reset asserted mid-CRS_WAIT -> all outputs 0 in the same cycle, without waiting for a clock edge.
- Stale-done and restart rules: scan_done held high from before the start -> not taken in SCAN_GO, only taken in SCAN_WAIT. cmd_start while busy -> no extra scan_start pulse.
